// File: rtl/mem_req_seq_pkg.sv
// mem_req_seq_pkg -- shared types and constants for the memory request
// sequencer: FSM state encoding, the queued request entry layout, the idle
// levels of the memory-side strobes and the four bank base addresses.
package mem_req_seq_pkg;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RECOVER = 2'd2,
    ST_WAIT_RD = 2'd3
  } state_t;

  // One queued request: {we, addr, wdata} = 25 bits.
  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } req_entry_t;

  localparam int ENTRY_W = $bits(req_entry_t);

  // Strobe levels whenever no access is being driven.
  localparam logic       IDLE_CE    = 1'b0;
  localparam logic       IDLE_CSB   = 1'b1;
  localparam logic       IDLE_WEB   = 1'b1;
  localparam logic       IDLE_OEB   = 1'b1;
  localparam logic [7:0] IDLE_IDATA = 8'h00;

  // Bank bases; address bits [15:14] select the bank.
  localparam logic [15:0] BANK0_BASE = 16'h0000;
  localparam logic [15:0] BANK1_BASE = 16'h4000;
  localparam logic [15:0] BANK2_BASE = 16'h8000;
  localparam logic [15:0] BANK3_BASE = 16'hC000;

endpackage : mem_req_seq_pkg

// File: rtl/mem_req_fifo.sv
// mem_req_fifo -- 2-entry request queue for mem_req_seq.
// Ports:
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset; flushes the queue
//   push       : write push_entry into the tail (ignored when full)
//   push_entry : request to enqueue
//   pop        : drop the head entry (ignored when empty)
//   head_entry : current head entry (meaningful only when count != 0)
//   count      : number of entries held (0..2)
// A simultaneous push and pop leaves count unchanged and preserves order.
module mem_req_fifo
  import mem_req_seq_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  req_entry_t push_entry,
  input  logic       pop,
  output req_entry_t head_entry,
  output logic [1:0] count
);

  localparam logic [1:0] DEPTH_C = 2'(DEPTH);

  req_entry_t mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic       do_push;
  logic       do_pop;

  assign do_push    = push && (count != DEPTH_C);
  assign do_pop     = pop  && (count != 2'd0);
  assign head_entry = mem[rd_ptr];

  // NOTE: storage is deliberately not reset; the pointers and count decide
  // which entries are live, so flushing them is enough and the array stays
  // plain registers without a reset mux.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop in the
  // design samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule : mem_req_fifo

// File: rtl/mem_req_seq.sv
// mem_req_seq -- sequences queued read/write requests onto a simple
// strobe-based memory controller interface.
// Ports:
//   CLK, RST             : clock, synchronous active-high reset
//   REQ_VALID/REQ_READY  : request handshake (accepted when both high at edge)
//   REQ_WE, REQ_ADDR,
//   REQ_WDATA            : request payload (1 = write)
//   RSP_VALID, RSP_RDATA : one-cycle read data pulse, data held otherwise
//   ADDR, CE, CSB, WEB,
//   OEB, IDATA           : registered memory controller outputs
//   ODATA                : memory controller read data
//   BUSY                 : FSM not idle or requests still queued
// Timing: a request accepted in cycle n into an empty, idle sequencer drives
// its strobes in n+2. Writes take ACCESS + RECOVER (2 cycles); reads take
// ACCESS + RD_LAT WAIT_RD cycles, with RSP_VALID one cycle after the last.
module mem_req_seq
  import mem_req_seq_pkg::*;
#(
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WE,
  input  logic [15:0] REQ_ADDR,
  input  logic [7:0]  REQ_WDATA,
  output logic        RSP_VALID,
  output logic [7:0]  RSP_RDATA,
  output logic [15:0] ADDR,
  output logic        CE,
  output logic        CSB,
  output logic        WEB,
  output logic        OEB,
  output logic [7:0]  IDATA,
  input  logic [7:0]  ODATA,
  output logic        BUSY
);

  localparam logic [1:0] DEPTH_C  = 2'(FIFO_DEPTH);
  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

  state_t     state;
  logic [1:0] wait_cnt;
  logic       cur_we;

  req_entry_t push_entry;
  req_entry_t head_entry;
  logic [1:0] fifo_count;
  logic       push;
  logic       pop;
  logic       issue_slot;

  // Ready comes only from the registered count, so a full queue refuses a
  // request even in a cycle where the FSM pops.
  assign REQ_READY  = (fifo_count < DEPTH_C) && !RST;
  assign push       = REQ_VALID && REQ_READY;
  assign push_entry = '{we: REQ_WE, addr: REQ_ADDR, wdata: REQ_WDATA};
  assign BUSY       = (state != ST_IDLE) || (fifo_count != 2'd0);

  // Cycles in which the FSM may start a new access: idle, or the final cycle
  // of a write recovery / read wait.
  // NOTE: every variable written here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    issue_slot = 1'b0;
    pop        = 1'b0;
    unique case (state)
      ST_IDLE:    issue_slot = 1'b1;
      ST_RECOVER: issue_slot = 1'b1;
      ST_WAIT_RD: issue_slot = (wait_cnt == 2'd0);
      default:    issue_slot = 1'b0;
    endcase
    pop = issue_slot && (fifo_count != 2'd0);
  end

  mem_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (CLK),
    .rst        (RST),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head_entry (head_entry),
    .count      (fifo_count)
  );

  // Sequencer FSM with all memory-side outputs registered. Strobes fall back
  // to idle levels every cycle unless a new access is launched; ADDR keeps
  // its last driven value.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      wait_cnt  <= 2'd0;
      cur_we    <= 1'b0;
      ADDR      <= 16'h0000;
      IDATA     <= IDLE_IDATA;
      CE        <= IDLE_CE;
      CSB       <= IDLE_CSB;
      WEB       <= IDLE_WEB;
      OEB       <= IDLE_OEB;
      RSP_VALID <= 1'b0;
      RSP_RDATA <= 8'h00;
    end else begin
      CE        <= IDLE_CE;
      CSB       <= IDLE_CSB;
      WEB       <= IDLE_WEB;
      OEB       <= IDLE_OEB;
      IDATA     <= IDLE_IDATA;
      RSP_VALID <= 1'b0;

      unique case (state)
        ST_ACCESS: begin
          if (cur_we) begin
            state <= ST_RECOVER;
          end else begin
            state    <= ST_WAIT_RD;
            wait_cnt <= LAT_LAST;
          end
        end
        ST_WAIT_RD: begin
          if (wait_cnt == 2'd0) begin
            // Edge ending the last wait cycle: capture read data.
            RSP_VALID <= 1'b1;
            RSP_RDATA <= ODATA;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        default: ;
      endcase

      // Launch the next access straight from any issue slot, or park in IDLE.
      if (pop) begin
        state  <= ST_ACCESS;
        cur_we <= head_entry.we;
        ADDR   <= head_entry.addr;
        CE     <= 1'b1;
        CSB    <= 1'b0;
        WEB    <= ~head_entry.we;
        OEB    <= head_entry.we;
        IDATA  <= head_entry.we ? head_entry.wdata : 8'h00;
      end else if (issue_slot) begin
        state <= ST_IDLE;
      end
    end
  end

endmodule : mem_req_seq

// File: tb/tb_mem_req_seq.sv
// tb_mem_req_seq -- directed self-checking bench for mem_req_seq (RD_LAT=1).
// Inputs are driven 1 time unit after each rising edge and outputs sampled
// at the same point, so each sample shows the state of that cycle.
module tb_mem_req_seq;
  import mem_req_seq_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WE;
  logic [15:0] REQ_ADDR;
  logic [7:0]  REQ_WDATA;
  logic        RSP_VALID;
  logic [7:0]  RSP_RDATA;
  logic [15:0] ADDR;
  logic        CE;
  logic        CSB;
  logic        WEB;
  logic        OEB;
  logic [7:0]  IDATA;
  logic [7:0]  ODATA;
  logic        BUSY;

  int errors = 0;
  int checks = 0;

  // Memory model: read data is presented only in the cycle after a read
  // strobe (RD_LAT = 1); any other cycle shows a distinct filler value.
  logic       rd_pend = 1'b0;
  logic [7:0] mem_rdata = 8'hA5;
  always @(posedge CLK) rd_pend <= CE && !OEB;
  assign ODATA = rd_pend ? mem_rdata : 8'hEE;

  always #5 CLK = ~CLK;

  mem_req_seq #(
    .RD_LAT     (1),
    .FIFO_DEPTH (2)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_WE    (REQ_WE),
    .REQ_ADDR  (REQ_ADDR),
    .REQ_WDATA (REQ_WDATA),
    .RSP_VALID (RSP_VALID),
    .RSP_RDATA (RSP_RDATA),
    .ADDR      (ADDR),
    .CE        (CE),
    .CSB       (CSB),
    .WEB       (WEB),
    .OEB       (OEB),
    .IDATA     (IDATA),
    .ODATA     (ODATA),
    .BUSY      (BUSY)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_idle_strobes(input string tag);
    check({tag, "_ce"},    32'(CE),    32'(IDLE_CE));
    check({tag, "_csb"},   32'(CSB),   32'(IDLE_CSB));
    check({tag, "_web"},   32'(WEB),   32'(IDLE_WEB));
    check({tag, "_oeb"},   32'(OEB),   32'(IDLE_OEB));
    check({tag, "_idata"}, 32'(IDATA), 32'(IDLE_IDATA));
  endtask

  logic [15:0] baddr [4];
  logic [7:0]  bdata [4];
  logic [10:0] burst_rdy;
  logic [10:0] burst_ce;

  initial begin
    int  wi;
    int  k;
    int  ce_seen;
    int  rsp_seen;
    logic accepted;

    RST = 1'b1;
    REQ_VALID = 1'b0;
    REQ_WE = 1'b0;
    REQ_ADDR = 16'h0000;
    REQ_WDATA = 8'h00;

    // ---------------- reset ----------------
    repeat (4) tick();
    check_idle_strobes("rst");
    check("rst_addr",      32'(ADDR),      32'h0000);
    check("rst_ready",     32'(REQ_READY), 32'h0);
    check("rst_rsp_valid", 32'(RSP_VALID), 32'h0);
    check("rst_rsp_rdata", 32'(RSP_RDATA), 32'h00);
    check("rst_busy",      32'(BUSY),      32'h0);
    RST = 1'b0;
    #1;
    check("rst_release_ready", 32'(REQ_READY), 32'h1);

    // ---------------- single write ----------------
    tick();                                          // cycle n
    REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_ADDR = BANK3_BASE; REQ_WDATA = 8'h5A;
    #1;
    check("wr_ready_n", 32'(REQ_READY), 32'h1);
    tick();                                          // n+1
    REQ_VALID = 1'b0;
    check("wr_n1_ce",   32'(CE),   32'h0);
    check("wr_n1_busy", 32'(BUSY), 32'h1);
    tick();                                          // n+2
    check("wr_n2_ce",    32'(CE),    32'h1);
    check("wr_n2_csb",   32'(CSB),   32'h0);
    check("wr_n2_web",   32'(WEB),   32'h0);
    check("wr_n2_oeb",   32'(OEB),   32'h1);
    check("wr_n2_addr",  32'(ADDR),  32'hC000);
    check("wr_n2_idata", 32'(IDATA), 32'h5A);
    tick();                                          // n+3 recover
    check_idle_strobes("wr_n3");
    check("wr_n3_addr_hold", 32'(ADDR), 32'hC000);
    check("wr_n3_busy",      32'(BUSY), 32'h1);
    tick();                                          // n+4 idle
    check("wr_n4_busy", 32'(BUSY), 32'h0);

    // ---------------- burst of 4 writes ----------------
    // Hand timeline (cycle 0 = first offer): strobes in cycles 2,4,6,8;
    // ready low in 3 and 5 when two requests are pending. Cycle 1 is a
    // push during a pop with one entry held; ready in cycle 2 shows count 1.
    baddr[0] = BANK0_BASE; baddr[1] = BANK1_BASE;
    baddr[2] = BANK2_BASE; baddr[3] = BANK3_BASE;
    bdata[0] = 8'h11; bdata[1] = 8'h22; bdata[2] = 8'h33; bdata[3] = 8'h44;
    burst_rdy = 11'b111_1101_0111;
    burst_ce  = 11'b001_0101_0100;
    wi = 0;
    k  = 0;
    for (int c = 0; c < 11; c++) begin
      if (wi < 4) begin
        REQ_VALID = 1'b1; REQ_WE = 1'b1;
        REQ_ADDR = baddr[wi]; REQ_WDATA = bdata[wi];
      end else begin
        REQ_VALID = 1'b0;
      end
      #1;
      check($sformatf("burst_ready_c%0d", c), 32'(REQ_READY), 32'(burst_rdy[c]));
      check($sformatf("burst_ce_c%0d", c),    32'(CE),        32'(burst_ce[c]));
      if (CE === 1'b1) begin
        if (k < 4) begin
          check($sformatf("burst_addr_%0d", k),  32'(ADDR),  32'(baddr[k]));
          check($sformatf("burst_idata_%0d", k), 32'(IDATA), 32'(bdata[k]));
          check($sformatf("burst_web_%0d", k),   32'(WEB),   32'h0);
        end
        k++;
      end
      accepted = REQ_VALID && REQ_READY;
      tick();
      if (accepted) wi++;
    end
    REQ_VALID = 1'b0;
    check("burst_accepted", 32'(wi),   32'd4);
    check("burst_issued",   32'(k),    32'd4);
    check("burst_busy_end", 32'(BUSY), 32'h0);

    // ---------------- single read, RD_LAT=1 ----------------
    REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_ADDR = BANK1_BASE; REQ_WDATA = 8'hFF;
    tick();                                          // n+1
    REQ_VALID = 1'b0;
    check("rd_n1_ce", 32'(CE), 32'h0);
    tick();                                          // n+2 access
    check("rd_n2_ce",    32'(CE),        32'h1);
    check("rd_n2_csb",   32'(CSB),       32'h0);
    check("rd_n2_web",   32'(WEB),       32'h1);
    check("rd_n2_oeb",   32'(OEB),       32'h0);
    check("rd_n2_addr",  32'(ADDR),      32'h4000);
    check("rd_n2_idata", 32'(IDATA),     32'h00);
    check("rd_n2_rsp",   32'(RSP_VALID), 32'h0);
    tick();                                          // n+3 wait
    check_idle_strobes("rd_n3");
    check("rd_n3_addr_hold", 32'(ADDR),      32'h4000);
    check("rd_n3_rsp",       32'(RSP_VALID), 32'h0);
    tick();                                          // n+4 response
    check("rd_n4_rsp",   32'(RSP_VALID), 32'h1);
    check("rd_n4_rdata", 32'(RSP_RDATA), 32'hA5);
    check("rd_n4_busy",  32'(BUSY),      32'h0);
    tick();                                          // n+5
    check("rd_n5_rsp",        32'(RSP_VALID), 32'h0);
    check("rd_n5_rdata_hold", 32'(RSP_RDATA), 32'hA5);

    // ---------------- reset during a read access ----------------
    REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_ADDR = BANK2_BASE; REQ_WDATA = 8'h00;
    tick();                                          // m+1
    REQ_WE = 1'b1; REQ_ADDR = BANK0_BASE; REQ_WDATA = 8'h77;
    tick();                                          // m+2 read access, 1 queued
    check("mid_m2_ce",   32'(CE),   32'h1);
    check("mid_m2_oeb",  32'(OEB),  32'h0);
    check("mid_m2_addr", 32'(ADDR), 32'h8000);
    RST = 1'b1;
    REQ_WE = 1'b1; REQ_ADDR = BANK3_BASE; REQ_WDATA = 8'h99;
    #1;
    check("mid_ready_in_rst", 32'(REQ_READY), 32'h0);
    tick();                                          // m+3
    check_idle_strobes("mid_m3");
    check("mid_m3_addr",  32'(ADDR),      32'h0000);
    check("mid_m3_rsp",   32'(RSP_VALID), 32'h0);
    check("mid_m3_busy",  32'(BUSY),      32'h0);
    tick();                                          // m+4, still in reset
    check("mid_m4_busy", 32'(BUSY), 32'h0);
    RST = 1'b0;
    REQ_VALID = 1'b0;
    ce_seen  = 0;
    rsp_seen = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (CE !== 1'b0) ce_seen++;
      if (RSP_VALID !== 1'b0) rsp_seen++;
    end
    check("mid_no_issue", 32'(ce_seen),  32'd0);
    check("mid_no_rsp",   32'(rsp_seen), 32'd0);
    check("mid_end_busy", 32'(BUSY),     32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mem_req_seq

// File: doc/mem_req_seq.md
MEM_REQ_SEQ -- requirements
Module: mem_req_seq

Interface
REQ-001 SHALL have parameter RD_LAT, default 1, meaning cycles from the strobe cycle to the cycle ODATA is valid (legal 1..3).
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, meaning the request queue depth (fixed at 2 in this revision).
REQ-003 SHALL have port CLK  input  1  single clock; all flops rising-edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port REQ_VALID  input  1  request present.
REQ-006 SHALL have port REQ_READY  output  1  request accepted when REQ_VALID and REQ_READY are both 1 at a rising edge.
REQ-007 SHALL have port REQ_WE  input  1  1 = write, 0 = read.
REQ-008 SHALL have port REQ_ADDR  input  16  byte address; bits [15:14] select bank (0x0000/0x4000/0x8000/0xC000).
REQ-009 SHALL have port REQ_WDATA  input  8  write data.
REQ-010 SHALL have port RSP_VALID  output  1  one-cycle read-data pulse, no backpressure.
REQ-011 SHALL have port RSP_RDATA  output  8  read data, valid only with RSP_VALID.
REQ-012 SHALL have ports ADDR (output, 16), CE, CSB, WEB, OEB (each output, 1) and IDATA (output, 8), driving the memory controller.
REQ-013 SHALL have port ODATA  input  8  memory controller read data.
REQ-014 SHALL have port BUSY  output  1  FSM not in IDLE, or FIFO non-empty.

Function
REQ-015 SHALL register every memory-side output; idle values are CE=0, CSB=1, WEB=1, OEB=1, IDATA=0x00, with ADDR holding its last driven value.
REQ-016 SHALL drive REQ_READY = (FIFO count < 2) and not RST, from registered count; there is no bypass when full even if a pop occurs in the same cycle.
REQ-017 SHALL leave the FIFO count unchanged on simultaneous push and pop; order is strictly FIFO.
REQ-018 SHALL implement FSM states IDLE, ACCESS, RECOVER, WAIT_RD.
REQ-019 IDLE: on FIFO non-empty, SHALL pop the head entry and go to ACCESS.
REQ-019a Latency: a request accepted in cycle n into an empty FIFO with the FSM in IDLE SHALL drive strobes in cycle n+2.
REQ-020 ACCESS (exactly 1 cycle) SHALL drive CE=1, CSB=0, ADDR=entry address; writes SHALL drive WEB=0, OEB=1, IDATA=wdata; reads SHALL drive WEB=1, OEB=0, IDATA=0x00.
REQ-021 After ACCESS, a write SHALL go to RECOVER for 1 cycle with strobes idle and ADDR held.
REQ-022 After ACCESS, a read SHALL go to WAIT_RD for RD_LAT cycles with strobes idle and ADDR held, sampling ODATA at the edge ending the last WAIT_RD cycle.
REQ-023 RSP_VALID SHALL be 1 for exactly the cycle after the ODATA sample, with RSP_RDATA = sampled value; RSP_RDATA SHALL hold otherwise.
REQ-024 On leaving RECOVER/WAIT_RD, the FSM SHALL go directly to ACCESS (popping) if the FIFO is non-empty, else to IDLE.
REQ-025 Throughput SHALL be 1 write per 2 cycles and 1 read per 1+RD_LAT cycles.

Reset
REQ-026 RST=1 at an edge SHALL clear the FSM to IDLE, flush the FIFO, set ADDR=0x0000, IDATA=0x00, CE=0, CSB=1, WEB=1, OEB=1, RSP_VALID=0, RSP_RDATA=0x00, BUSY=0.
REQ-027 Reset mid-access SHALL abandon the access with no RSP_VALID, and SHALL accept no request while RST=1.

Structure
REQ-028 Package mem_req_seq_pkg SHALL hold the FSM state enum, idle strobe constants and the four bank base-address constants.
REQ-029 The queue SHALL be a sub-module mem_req_fifo (2-entry, 25-bit entries {we, addr, wdata}, push/pop/count).

Verification
REQ-030 Reset: RST=1 for 4 cycles -> CE=0, CSB=1, WEB=1, OEB=1, ADDR=0x0000, REQ_READY=0, RSP_VALID=0, BUSY=0.
REQ-031 Single write: addr 0xC000, data 0x5A accepted in cycle n -> cycle n+2 shows CE=1, CSB=0, WEB=0, OEB=1, ADDR=0xC000, IDATA=0x5A, and idle strobes in n+3.
REQ-032 Burst: 4 writes at 0x0000/0x4000/0x8000/0xC000 offered back-to-back -> REQ_READY drops when 2 are pending, strobes appear every 2 cycles in order, no write is lost.
REQ-033 Read: RD_LAT=1, addr 0x4000, memory model returns 0xA5 -> ACCESS in n+2 with OEB=0, RSP_VALID=1 with RSP_RDATA=0xA5 in n+4 only.
REQ-034 Reset mid-op: RST=1 during a read ACCESS with 1 entry queued -> strobes idle the next cycle, no RSP_VALID, BUSY=0, queued entry never issued.
REQ-035 Concurrency: push during the pop cycle with count=1 -> count stays 1 and both requests issue in acceptance order.
